// File: rtl/mem_access_unit_if.sv
// Bus-side signal bundle between the memory access unit (master) and the data
// memory / bus slave.
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns pipeline requests into single bus transactions,
// stalls the pipeline while the bus is busy, and reports misalignment and bus timeouts.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Mi_memRead,
    input  logic        Mi_memWrite,
    input  logic [1:0]  Mi_memSize,
    input  logic [31:0] Mi_addr,
    input  logic [31:0] Mi_writeData,
    output logic [31:0] Mo_readData,
    output logic        Mo_stall,
    output logic        Mo_misaligned,
    output logic        Mo_busErr,
    mem_access_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q;
    logic [31:0] rd_q;
    logic        err_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;

    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;

    logic        access;
    logic        misaligned;
    logic        timeout_hit;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] rdata_lane;

    assign access     = Mi_memRead | Mi_memWrite;
    assign misaligned = ((Mi_memSize == 2'b01) && Mi_addr[0]) ||
                        (Mi_memSize[1] && (Mi_addr[1:0] != 2'b00));

    // cnt_q counts BUSY cycles already finished, so +1 includes the current one.
    assign timeout_hit = ({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT);

    // Byte enables and lane-replicated store data for the request being presented.
    always_comb begin
        be_d    = 4'b0000;
        wdata_d = '0;
        case (Mi_memSize)
            2'b00: begin
                be_d    = 4'b0001 << Mi_addr[1:0];
                wdata_d = {4{Mi_writeData[7:0]}};
            end
            2'b01: begin
                be_d    = Mi_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{Mi_writeData[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = Mi_writeData;
            end
        endcase
    end

    // Lane extraction uses the offset/size latched at request time.
    always_comb begin
        rdata_lane = '0;
        case (size_q)
            2'b00:   rdata_lane = {24'd0, bus.bus_rdata[{off_q, 3'b000} +: 8]};
            2'b01:   rdata_lane = off_q[1] ? {16'd0, bus.bus_rdata[31:16]}
                                           : {16'd0, bus.bus_rdata[15:0]};
            default: rdata_lane = bus.bus_rdata;
        endcase
    end

    // NOTE: every output of this block gets a default first, otherwise paths that
    // skip an assignment would infer latches.
    always_comb begin
        state_d       = state_q;
        Mo_stall      = 1'b0;
        Mo_misaligned = 1'b0;
        Mo_busErr     = 1'b0;
        Mo_readData   = '0;
        case (state_q)
            IDLE: begin
                // Gated by reset so a request held during reset does not stall.
                if (access && !reset) begin
                    if (misaligned) begin
                        Mo_misaligned = 1'b1;
                    end else begin
                        Mo_stall = 1'b1;
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                Mo_stall = 1'b1;
                if (bus.bus_ready || timeout_hit) state_d = DONE;
            end
            DONE: begin
                Mo_readData = rd_q;
                Mo_busErr   = err_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            off_q   <= '0;
            size_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (state_d == BUSY) begin
                        req_q   <= 1'b1;
                        we_q    <= Mi_memWrite;
                        addr_q  <= {Mi_addr[31:2], 2'b00};
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        off_q   <= Mi_addr[1:0];
                        size_q  <= Mi_memSize;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (bus.bus_ready) begin
                        req_q <= 1'b0;
                        rd_q  <= rdata_lane;
                        err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        req_q <= 1'b0;
                        rd_q  <= '0;
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Clocking: one clock; reset is asynchronous and active-high.
REQ-002 Parameter TIMEOUT, default 255: maximum BUSY cycles without bus_ready before a bus error is declared (range 1..65535).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 Mi_memRead  input  1  MEM-stage load request.
REQ-006 Mi_memWrite  input  1  MEM-stage store request.
REQ-007 Mi_memSize  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 Mi_addr  input  32  byte address (EX/MEM ALU result).
REQ-009 Mi_writeData  input  32  store data, right-justified.
REQ-010 Mo_readData  output  32  load data, right-justified, zero-padded; sign extension is done downstream.
REQ-011 Mo_stall  output  1  freeze IF..MEM stages this cycle.
REQ-012 Mo_misaligned  output  1  misaligned-access flag (combinational).
REQ-013 Mo_busErr  output  1  one-cycle timeout flag.
REQ-014 bus_req  output  1  bus request, registered.
REQ-015 bus_we  output  1  1 = write.
REQ-016 bus_addr  output  32  word address, {Mi_addr[31:2], 2'b00}.
REQ-017 bus_be  output  4  byte enables.
REQ-018 bus_wdata  output  32  lane-placed write data.
REQ-019 bus_ready  input  1  slave completion, sampled only while bus_req=1.
REQ-020 bus_rdata  input  32  read word, valid when bus_ready=1.

Function
REQ-021 States: IDLE, BUSY, DONE. Access = Mi_memRead | Mi_memWrite. Mi_memWrite has priority when both are set.
REQ-022 Misaligned: half with addr[0]=1, or word with addr[1:0]!=00. Mo_misaligned=1 only in IDLE with an access pending. No bus request is issued, Mo_stall=0, and the state remains IDLE.
REQ-023 IDLE with an aligned access: Mo_stall=1. Next state is BUSY. bus_req, bus_we, bus_addr, bus_be and bus_wdata are registered at that edge.
REQ-024 BUSY: bus_req=1 and Mo_stall=1. All bus outputs are held stable. A 16-bit cycle counter increments.
REQ-025 BUSY with bus_ready=1: bus_rdata is lane-extracted into the read register, bus_req is cleared, and next state is DONE.
REQ-026 BUSY with the counter equal to TIMEOUT and bus_ready=0: bus_req is cleared, the read register is cleared to 0, Mo_busErr=1 during the following DONE cycle, and next state is DONE.
REQ-027 DONE: Mo_stall=0 and Mo_readData = read register. The still-presented request is not reissued. Next state is IDLE unconditionally.
REQ-028 Latency: with bus_ready in the first BUSY cycle, the access occupies 3 cycles (IDLE, BUSY, DONE), giving 2 stall cycles. Each extra wait cycle adds 1 stall cycle.
REQ-029 Byte enables: byte = 4'b0001 << addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111. Enables are also driven on reads.
REQ-030 Write lanes: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
REQ-031 Read extraction: byte = rdata byte addr[1:0] at [7:0]; half = rdata[31:16] if addr[1], else rdata[15:0]; word = rdata. Upper bits are 0.
REQ-032 Mo_readData is 0 outside DONE.
REQ-033 The counter clears on every IDLE->BUSY transition.
REQ-034 A new access presented in the cycle after DONE is handled from IDLE with no idle gap.
REQ-035 bus_ready while bus_req=0 is ignored.

Reset
REQ-036 During reset: state=IDLE, counter=0, read register=0.
REQ-037 During reset: bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0.
REQ-038 During reset: Mo_stall=0, Mo_misaligned=0, Mo_busErr=0.
REQ-039 Reset asserted in BUSY abandons the transaction immediately. bus_req falls asynchronously and nothing is reissued after release.

Verification
REQ-040 Word load addr 0x1004, bus_ready in first BUSY cycle, rdata 0xDEADBEEF -> bus_addr 0x1004, be 1111, 2 stall cycles, DONE Mo_readData 0xDEADBEEF.
REQ-041 Byte store addr 0x2003, wdata 0x000000A5 -> bus_we=1, be 1000, bus_wdata 0xA5A5A5A5, Mo_stall high exactly 2 cycles.
REQ-042 Half load addr 0x3002, rdata 0x8001_7FFF, bus_ready delayed 3 cycles -> 5 stall cycles, Mo_readData 0x00008001.
REQ-043 Half load addr 0x3001 -> Mo_misaligned=1, bus_req never rises, Mo_stall=0.
REQ-044 TIMEOUT=4, bus_ready held 0 -> bus_req drops after 4 BUSY cycles, one-cycle Mo_busErr=1, Mo_readData=0.
REQ-045 Reset pulse mid-BUSY -> bus_req=0 and Mo_stall=0 within the same cycle; the first access after release starts from IDLE with a fresh counter.
